// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request/grant bundle; master drives en/prio_mode/req, slave (arbiter) drives gnt/gnt_id/gnt_valid
interface rr_arbiter8_if;
  logic       en;
  logic       prio_mode;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  modport master (output en, prio_mode, req, input gnt, gnt_id, gnt_valid);
  modport slave (input en, prio_mode, req, output gnt, gnt_id, gnt_valid);
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way fixed/round-robin arbiter with hold limit; ports clk, rst (sync, active-high), bus (slave: en, prio_mode, req -> gnt, gnt_id, gnt_valid)
module rr_arbiter8 #(
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter8_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [7:0] LAST = 8'(MAX_HOLD - 1);
  state_t     state;
  logic [7:0] hold_cnt;
  logic [2:0] rr_ptr, fix_id, rr_id, win;
  always_comb begin
    fix_id = '0;
    rr_id = '0;
    for (int i = 0; i < 8; i++) if (bus.req[i]) fix_id = 3'(i);
    for (int i = 7; i >= 0; i--) if (bus.req[rr_ptr + 3'(i)]) rr_id = rr_ptr + 3'(i);
    win = bus.prio_mode ? fix_id : rr_id;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.gnt <= '0;
      bus.gnt_id <= '0;
      bus.gnt_valid <= 1'b0;
      hold_cnt <= '0;
      rr_ptr <= '0;
    end else if (state == IDLE) begin
      if (bus.en && |bus.req) begin
        state <= GRANT;
        bus.gnt <= 8'b1 << win;
        bus.gnt_id <= win;
        bus.gnt_valid <= 1'b1;
        hold_cnt <= '0;
        rr_ptr <= win + 3'd1;
      end
    end else if (!bus.en || !bus.req[bus.gnt_id] || hold_cnt == LAST) begin
      state <= IDLE;
      bus.gnt <= '0;
      bus.gnt_id <= '0;
      bus.gnt_valid <= 1'b0;
    end else begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end
endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- 8-requester arbiter that shares one resource slot between requesters. It is the sequential controller built around the 8-to-3 priority-encode function.
- Supports fixed priority, where the highest index wins, and round-robin priority.
- Issues a registered one-hot grant plus a 3-bit encoded grant ID.
- Each grant lasts until the requester drops its request or a hold limit expires.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one grant may be held. Legal range 1..256.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  arbiter enable, active-high. While low, no new grant is issued and any active grant is released.
- prio_mode  input  1  0 = round-robin, 1 = fixed priority (highest index wins)
- req  input  8  request vector, bit i = requester i
- gnt  output  8  one-hot grant vector, all zero when idle
- gnt_id  output  3  binary index of the granted requester, 0 when idle
- gnt_valid  output  1  high while a grant is active

Behaviour:
- Reset, sampled at the clk edge while rst=1:
  - state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, hold_cnt=0, rr_ptr=0.
  - rst overrides every other input, including mid-grant. The grant drops at that edge.
- Two states, IDLE and GRANT. All outputs are registered.
- IDLE:
  - If en=1 and req!=0 at an edge: arbitrate, load the winner into gnt/gnt_id, set gnt_valid=1, hold_cnt=0, go to GRANT.
  - Latency from request to grant is 1 clock.
  - Otherwise stay in IDLE with outputs 0.
- Arbitration:
  - Fixed (prio_mode=1): the highest set bit of req wins (7 > 6 > ... > 0).
  - Round-robin (prio_mode=0): search req upward starting at rr_ptr, wrapping 7->0. The first set bit wins.
  - prio_mode is sampled only at the arbitration edge. Changing it mid-grant has no effect until the next arbitration.
- GRANT: at each edge, the grant is released if any of these hold:
  - en=0
  - req[gnt_id]=0
  - hold_cnt == MAX_HOLD-1
- On release: go to IDLE, gnt=0, gnt_id=0, gnt_valid=0. Otherwise hold_cnt increments and the outputs hold.
- Grant duration and gaps:
  - A grant is visible for 1..MAX_HOLD cycles.
  - There is always exactly one idle cycle (gnt_valid=0) between consecutive grants. There is no back-to-back re-grant in the release cycle.
- rr_ptr:
  - Updated at every arbitration edge, in both modes, to (winner+1) mod 8.
  - Winner 7 sets rr_ptr to 0.
  - Not changed on release.
- Changes to other req bits during GRANT are ignored. Requests are not latched; only live req at the arbitration edge counts.
- MAX_HOLD=1: every grant lasts exactly 1 cycle, then 1 idle cycle.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt == (1<<gnt_id) whenever gnt_valid=1.
  - gnt_valid == (gnt!=0).
- hold_cnt is 8 bits wide. It never exceeds MAX_HOLD-1.

Test Plan:
- Reset: rst=1 for 2 cycles with req=0xFF, en=1 -> gnt=0x00, gnt_id=0, gnt_valid=0. First grant after rst falls goes to requester 0 in round-robin mode (rr_ptr=0).
- Fixed priority: prio_mode=1, en=1, req=8'b1010_0100 -> one clock later gnt=0x80, gnt_id=7, gnt_valid=1, held 4 cycles (MAX_HOLD=4). Then 1 idle cycle, then gnt=0x80 again.
- Round-robin fairness: prio_mode=0, req=0xFF constant, MAX_HOLD=4 -> gnt_id sequence 0,1,2,...,7,0. Each ID lasts 4 cycles, separated by 1 idle cycle.
- Early release: prio_mode=0, rr_ptr=3, req=0x08, then req[3] drops after the 2nd grant cycle -> gnt_valid falls at the next edge. rr_ptr=4, and with req=0x09 the next grant is ID 0.
- Enable and reset mid-grant:
  - en=0 during a grant to ID 5 -> grant released at the next edge. No grant while en=0, even with req=0xFF.
  - rst=1 mid-grant -> outputs 0 at that edge, and rr_ptr returns to 0.
- Mode switch and MAX_HOLD=1:
  - Toggle prio_mode mid-grant -> the current grant is unaffected, and the new mode applies at the next arbitration.
  - With MAX_HOLD=1 and req=0xFF -> 1-cycle grants alternating with 1 idle cycle.
